// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and word/address types for the
// parametrised register file with integrated busy scoreboard.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   function automatic int addr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef logic [XLEN_DEF-1:0]               word_t;
   typedef logic [addr_w(NREGS_DEF)-1:0]      regaddr_t;

endpackage

// File: rtl/regfile_scb_scoreboard.sv
// Busy scoreboard: one busy bit per register, set on issue and cleared on
// write-back (issue wins on the same address), plus a registered busy count.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int NCLR     = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = addr_w(NREGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                set,
   input  logic [AW-1:0]       set_a,
   input  logic [NCLR-1:0]     clr,
   input  logic [NCLR*AW-1:0]  clr_a,
   input  logic [NRD*AW-1:0]   look_a,
   output logic [NRD-1:0]      look_busy,
   output logic [AW:0]         busy_cnt
);

   logic [NREGS-1:0] busy_reg, busy_next;
   logic [AW:0]      cnt_reg, cnt_next;
   logic             set_ok;
   logic             inc;
   logic [NCLR-1:0]  clr_ok;
   logic [NCLR-1:0]  dec;

   assign set_ok = set && !((ZERO_REG != 0) && (set_a == '0));
   assign inc    = set_ok && !busy_reg[set_a];

   genvar gi;
   generate
      for (gi = 0; gi < NCLR; gi++) begin : g_clr
         assign clr_ok[gi] = clr[gi] && !((ZERO_REG != 0) && (clr_a[gi*AW +: AW] == '0));
      end
   endgenerate

   // A clear only counts when the register was busy, is not re-issued this
   // cycle, and has not already been counted by a lower-numbered port.
   always_comb begin
      dec = '0;
      for (int k = 0; k < NCLR; k++) begin
         dec[k] = clr_ok[k] && busy_reg[clr_a[k*AW +: AW]]
                  && !(set_ok && (set_a == clr_a[k*AW +: AW]));
         for (int j = 0; j < k; j++) begin
            if (clr_ok[j] && (clr_a[j*AW +: AW] == clr_a[k*AW +: AW]))
               dec[k] = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_next = cnt_reg + {{AW{1'b0}}, inc};
      for (int k = 0; k < NCLR; k++)
         cnt_next = cnt_next - {{AW{1'b0}}, dec[k]};
   end

   always_comb begin
      busy_next = busy_reg;
      for (int k = 0; k < NCLR; k++) begin
         if (clr_ok[k])
            busy_next[clr_a[k*AW +: AW]] = 1'b0;
      end
      if (set_ok)
         busy_next[set_a] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_reg <= '0;
         cnt_reg  <= '0;
      end else begin
         busy_reg <= busy_next;
         cnt_reg  <= cnt_next;
      end
   end

   generate
      for (gi = 0; gi < NRD; gi++) begin : g_look
         assign look_busy[gi] = busy_reg[look_a[gi*AW +: AW]];
      end
   endgenerate

   assign busy_cnt = cnt_reg;

endmodule

// File: rtl/regfile_scb.sv
// Parametrised register file with write-to-read bypass and busy scoreboard.
// Define REGFILE_WP2_EN to add a second write port (we2/wa2/wd2).
module regfile_scb
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = addr_w(NREGS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 we,
   input  logic [AW-1:0]        wa,
   input  logic [XLEN-1:0]      wd,
   input  logic [NRD*AW-1:0]    ra,
   output logic [NRD*XLEN-1:0]  rd,
   output logic [NRD-1:0]       rbusy,
   input  logic                 iss,
   input  logic [AW-1:0]        iss_a,
   output logic [AW:0]          busy_cnt
`ifdef REGFILE_WP2_EN
   ,
   input  logic                 we2,
   input  logic [AW-1:0]        wa2,
   input  logic [XLEN-1:0]      wd2
`endif
);

`ifdef REGFILE_WP2_EN
   localparam int NWP = 2;
`else
   localparam int NWP = 1;
`endif

   logic [XLEN-1:0]   mem_reg [NREGS];
   logic              we_ok, we2_ok;
   logic [AW-1:0]     wa2_i;
   logic [XLEN-1:0]   wd2_i;
   logic [NWP-1:0]    clr_v;
   logic [NWP*AW-1:0] clr_av;
   logic [NRD-1:0]    look_busy;

   // Writes are masked while reset is held so no bypass leaks through.
   assign we_ok = reset_n && we && !((ZERO_REG != 0) && (wa == '0));

`ifdef REGFILE_WP2_EN
   assign we2_ok = reset_n && we2 && !((ZERO_REG != 0) && (wa2 == '0));
   assign wa2_i  = wa2;
   assign wd2_i  = wd2;
   assign clr_v  = {we2_ok, we_ok};
   assign clr_av = {wa2_i, wa};
`else
   assign we2_ok = 1'b0;
   assign wa2_i  = '0;
   assign wd2_i  = '0;
   assign clr_v  = we_ok;
   assign clr_av = wa;
`endif

   // Port 2 is assigned last so it wins a same-address conflict.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++)
            mem_reg[i] <= '0;
      end else begin
         if (we_ok)
            mem_reg[wa] <= wd;
         if (we2_ok)
            mem_reg[wa2_i] <= wd2_i;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0] a;
         logic          byp1, byp2, zero_hit;
         assign a        = ra[gi*AW +: AW];
         assign byp1     = we_ok  && (wa    == a);
         assign byp2     = we2_ok && (wa2_i == a);
         assign zero_hit = (ZERO_REG != 0) && (a == '0);
         assign rd[gi*XLEN +: XLEN] = zero_hit ? '0    :
                                      byp2     ? wd2_i :
                                      byp1     ? wd    : mem_reg[a];
         assign rbusy[gi] = look_busy[gi] && !byp1 && !byp2;
      end
   endgenerate

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .NRD      (NRD),
      .NCLR     (NWP),
      .ZERO_REG (ZERO_REG)
   ) u_scb (
      .clk       (clk),
      .reset_n   (reset_n),
      .set       (iss),
      .set_a     (iss_a),
      .clr       (clr_v),
      .clr_a     (clr_av),
      .look_a    (ra),
      .look_busy (look_busy),
      .busy_cnt  (busy_cnt)
   );

endmodule

// File: tb/tb_regfile_scb.sv
// Randomised self-checking bench for regfile_scb against an array-based
// reference model; directed cases cover reset, bypass, r0 and scoreboard.
module tb_regfile_scb;
   import regfile_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                we;
   logic [AW-1:0]       wa;
   logic [XLEN-1:0]     wd;
   logic [NRD*AW-1:0]   ra;
   logic [NRD*XLEN-1:0] rd;
   logic [NRD-1:0]      rbusy;
   logic                iss;
   logic [AW-1:0]       iss_a;
   logic [AW:0]         busy_cnt;
`ifdef REGFILE_WP2_EN
   logic                we2;
   logic [AW-1:0]       wa2;
   logic [XLEN-1:0]     wd2;
`endif

   regfile_scb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .ra       (ra),
      .rd       (rd),
      .rbusy    (rbusy),
      .iss      (iss),
      .iss_a    (iss_a),
      .busy_cnt (busy_cnt)
`ifdef REGFILE_WP2_EN
      ,
      .we2      (we2),
      .wa2      (wa2),
      .wd2      (wd2)
`endif
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   int          txn         = 0;
   word_t       mem_m  [NREGS];
   bit          busy_m [NREGS];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic word_t model_rd(input int a);
      if (a == 0) return '0;
`ifdef REGFILE_WP2_EN
      if (we2 && int'(wa2) == a) return wd2;
`endif
      if (we && int'(wa) == a) return wd;
      return mem_m[a];
   endfunction

   function automatic bit model_rbusy(input int a);
      bit byp;
      byp = we && int'(wa) == a;
`ifdef REGFILE_WP2_EN
      byp = byp || (we2 && int'(wa2) == a);
`endif
      return busy_m[a] && !byp;
   endfunction

   function automatic int model_cnt();
      int n = 0;
      for (int i = 0; i < NREGS; i++) n += busy_m[i];
      return n;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NREGS; i++) begin
         mem_m[i]  = '0;
         busy_m[i] = 1'b0;
      end
   endtask

   // Registers written this edge lose busy, then any issue marks its target busy.
   task automatic model_edge();
      if (we && wa != 0) begin
         mem_m[wa]  = wd;
         busy_m[wa] = 1'b0;
      end
`ifdef REGFILE_WP2_EN
      if (we2 && wa2 != 0) begin
         mem_m[wa2]  = wd2;
         busy_m[wa2] = 1'b0;
      end
`endif
      if (iss && iss_a != 0) busy_m[iss_a] = 1'b1;
   endtask

   task automatic check_outputs(input string ctx);
      for (int i = 0; i < NRD; i++) begin
         int a;
         a = int'(ra[i*AW +: AW]);
         check($sformatf("%s rd%0d", ctx, i), 64'(rd[i*XLEN +: XLEN]), 64'(model_rd(a)));
         check($sformatf("%s rbusy%0d", ctx, i), 64'(rbusy[i]), 64'(model_rbusy(a)));
      end
      check($sformatf("%s busy_cnt", ctx), 64'(busy_cnt), 64'(model_cnt()));
   endtask

   task automatic drive(input logic w, input int a, input word_t d, input int r0, input int r1,
                        input logic i, input int ia);
      we    = w;
      wa    = a[AW-1:0];
      wd    = d;
      ra    = {r1[AW-1:0], r0[AW-1:0]};
      iss   = i;
      iss_a = ia[AW-1:0];
`ifdef REGFILE_WP2_EN
      we2   = 1'b0;
      wa2   = '0;
      wd2   = '0;
`endif
   endtask

   task automatic cycle(input string ctx);
      #1;
      check_outputs(ctx);
      @(posedge clk);
      model_edge();
      $display("txn %0d %s we=%0b wa=%0d wd=%h ra=%0d/%0d iss=%0b iss_a=%0d cnt=%0d",
               txn, ctx, we, wa, wd, ra[AW-1:0], ra[2*AW-1:AW], iss, iss_a, model_cnt());
      txn++;
      #1;
   endtask

   task automatic async_reset(input string ctx, input int r0);
      drive(1'b0, 0, '0, r0, 0, 1'b0, 0);
      reset_n = 1'b0;
      #1;
      model_clear();
      check_outputs(ctx);
      check({ctx, " rd0 cold"}, 64'(rd[XLEN-1:0]), 64'h0);
      @(posedge clk);
      #1;
      check_outputs({ctx, " held"});
      reset_n = 1'b1;
   endtask

   initial begin
      model_clear();
      drive(1'b0, 0, '0, 0, 0, 1'b0, 0);
      reset_n = 1'b0;
      #1;
      check_outputs("por");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset clears storage and scoreboard mid-run without a clock edge
      drive(1'b1, 5, 32'hDEADBEEF, 5, 0, 1'b1, 2); cycle("wr r5");
      drive(1'b0, 0, '0, 5, 2, 1'b0, 0);           cycle("rd r5");
      check("r5 stored", 64'(rd[XLEN-1:0]), 64'hDEADBEEF);
      #2;
      async_reset("arst", 5);

      // Bypass gated by write enable
      drive(1'b1, 7, 32'h12345678, 7, 0, 1'b0, 0);
      #1;
      check("byp rd0", 64'(rd[XLEN-1:0]), 64'h12345678);
      cycle("byp");
      drive(1'b1, 7, 32'h1, 0, 0, 1'b0, 0);        cycle("wr r7");
      drive(1'b0, 7, 32'hCAFEF00D, 7, 0, 1'b0, 0); cycle("nobyp");
      check("nobyp rd0", 64'(rd[XLEN-1:0]), 64'h1);

      // Register 0
      drive(1'b1, 0, 32'hFFFFFFFF, 0, 0, 1'b0, 0); cycle("r0 wr");
      drive(1'b0, 0, '0, 0, 0, 1'b1, 0);           cycle("r0 iss");
      drive(1'b0, 0, '0, 0, 0, 1'b0, 0);           cycle("r0 after");
      check("r0 cnt", 64'(busy_cnt), 64'h0);

      // Scoreboard set/clear
      drive(1'b0, 0, '0, 3, 9, 1'b1, 3);           cycle("iss r3");
      drive(1'b0, 0, '0, 3, 9, 1'b1, 9);           cycle("iss r9");
      drive(1'b0, 0, '0, 3, 9, 1'b0, 0);           cycle("busy");
      check("cnt two", 64'(busy_cnt), 64'h2);
      check("rbusy r3", 64'(rbusy[0]), 64'h1);
      drive(1'b1, 3, 32'h00C0FFEE, 3, 9, 1'b0, 0); cycle("wb r3");
      drive(1'b0, 0, '0, 3, 9, 1'b0, 0);           cycle("post wb");
      check("cnt one", 64'(busy_cnt), 64'h1);

      // Issue and write collision on a busy register
      drive(1'b0, 0, '0, 4, 0, 1'b1, 4);           cycle("iss r4");
      drive(1'b1, 4, 32'h44444444, 4, 0, 1'b1, 4); cycle("coll");
      drive(1'b0, 0, '0, 4, 0, 1'b0, 0);           cycle("post coll");
      check("coll cnt", 64'(busy_cnt), 64'h2);
      check("coll rbusy", 64'(rbusy[0]), 64'h1);
      check("coll rd", 64'(rd[XLEN-1:0]), 64'h44444444);

`ifdef REGFILE_WP2_EN
      drive(1'b0, 0, '0, 6, 0, 1'b1, 6);           cycle("iss r6");
      drive(1'b1, 6, 32'hA, 6, 0, 1'b0, 0);
      we2 = 1'b1; wa2 = 5'd6; wd2 = 32'hB;
      #1;
      check("wp2 byp", 64'(rd[XLEN-1:0]), 64'hB);
      cycle("wp2 coll");
      drive(1'b0, 0, '0, 6, 0, 1'b0, 0);           cycle("post wp2");
      check("wp2 rd", 64'(rd[XLEN-1:0]), 64'hB);
      check("wp2 cnt", 64'(busy_cnt), 64'h2);
`endif

      // Randomised traffic, biased toward low addresses to provoke collisions
      for (int n = 0; n < 400; n++) begin
         int a, r0, r1, ia;
         a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         r0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         r1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         ia = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         drive(1'($urandom_range(0, 1)), a, word_t'($urandom), r0, r1, 1'($urandom_range(0, 1)), ia);
`ifdef REGFILE_WP2_EN
         we2 = 1'($urandom_range(0, 1));
         wa2 = 5'($urandom_range(0, 7));
         wd2 = word_t'($urandom);
`endif
         if (n == 200) begin
            #2;
            async_reset("rnd arst", r0);
         end else begin
            cycle("rnd");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
